// File: rtl/vend_ctrl.sv
// vend_ctrl: coin credit, priced item vend and greedy change return.
// Optional inactivity refund enabled with `define VEND_TIMEOUT_EN.
module vend_ctrl #(
  parameter int CREDIT_W = 8,
  parameter int N_ITEMS = 4,
  parameter int SEL_W = 3,
  parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICES =
    {8'd50, 8'd25, 8'd20, 8'd15},
  parameter int MAX_CREDIT = 100,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_item,
  input  logic                vend_ready,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                err_sel
);

  typedef enum logic [1:0] {
    IDLE, CREDIT, VEND, CHANGE
  } state_t;

  state_t state;
  logic [CREDIT_W-1:0] price_q;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] vend_rem;
  logic [CREDIT_W-1:0] chg_rem;
  logic sel_ok, coin_ok, tmo_hit;
  logic do_cancel, do_sel, bad_sel;

  function automatic logic [CREDIT_W:0] coin_value(
    input logic [1:0] t
  );
    unique case (t)
      2'b00: coin_value = (CREDIT_W+1)'(5);
      2'b01: coin_value = (CREDIT_W+1)'(10);
      2'b10: coin_value = (CREDIT_W+1)'(25);
      default: coin_value = (CREDIT_W+1)'(100);
    endcase
  endfunction

  function automatic logic [1:0] chg_pick(
    input logic [CREDIT_W-1:0] c
  );
    if (c >= CREDIT_W'(25)) chg_pick = 2'b10;
    else if (c >= CREDIT_W'(10)) chg_pick = 2'b01;
    else chg_pick = 2'b00;
  endfunction

  function automatic logic [CREDIT_W-1:0] chg_value(
    input logic [1:0] k
  );
    unique case (k)
      2'b10: chg_value = CREDIT_W'(25);
      2'b01: chg_value = CREDIT_W'(10);
      default: chg_value = CREDIT_W'(5);
    endcase
  endfunction

  // price lookup, affordability, coin fit and action priority
  always_comb begin
    sel_ok = 1'b0;
    sel_price = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ok = 1'b1;
        sel_price = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    sum = {1'b0, credit} + coin_value(coin_type);
    coin_ok = sum <= (CREDIT_W+1)'(MAX_CREDIT);
    do_cancel = (cancel && state == CREDIT) || tmo_hit;
    do_sel = !do_cancel && sel_valid && sel_ok
             && credit >= sel_price;
    bad_sel = !do_cancel && sel_valid && !do_sel;
    vend_rem = credit - price_q;
    chg_rem = credit - chg_value(chg_coin);
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic tmo_act;

  assign tmo_act = sel_valid || (coin_valid && coin_ok);
  assign tmo_hit = state == CREDIT
                   && tmo_cnt == TW'(TIMEOUT_CYC);

  // inactivity counter, only runs while holding credit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt <= '0;
    else if (state != CREDIT || tmo_act) tmo_cnt <= '0;
    else if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC != 0);
  assign tmo_hit = 1'b0;
`endif

  // main controller with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      credit <= '0;
      price_q <= '0;
      vend_valid <= 1'b0;
      vend_item <= '0;
      chg_valid <= 1'b0;
      chg_coin <= 2'b00;
      busy <= 1'b0;
      coin_reject <= 1'b0;
      err_sel <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      err_sel <= 1'b0;
      unique case (state)
        IDLE, CREDIT: begin
          if (do_cancel) begin
            state <= CHANGE;
            chg_valid <= 1'b1;
            chg_coin <= chg_pick(credit);
            busy <= 1'b1;
            coin_reject <= coin_valid;
          end else if (do_sel) begin
            state <= VEND;
            vend_valid <= 1'b1;
            vend_item <= sel;
            price_q <= sel_price;
            busy <= 1'b1;
            coin_reject <= coin_valid;
          end else begin
            err_sel <= bad_sel;
            if (coin_valid) begin
              if (coin_ok) begin
                credit <= sum[CREDIT_W-1:0];
                state <= CREDIT;
              end else begin
                coin_reject <= 1'b1;
              end
            end
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          if (vend_valid && vend_ready) begin
            vend_valid <= 1'b0;
            credit <= vend_rem;
            if (vend_rem != '0) begin
              state <= CHANGE;
              chg_valid <= 1'b1;
              chg_coin <= chg_pick(vend_rem);
            end else begin
              state <= IDLE;
              busy <= 1'b0;
            end
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          if (chg_valid && chg_ready) begin
            credit <= chg_rem;
            if (chg_rem == '0) begin
              state <= IDLE;
              chg_valid <= 1'b0;
              busy <= 1'b0;
            end else begin
              chg_coin <= chg_pick(chg_rem);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scoreboard bench for vend_ctrl.
// Vend items and change coins are queued and checked on handshake.
module tb_vend_ctrl;
  localparam int CW = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic sel_valid = 1'b0;
  logic [SW-1:0] sel = '0;
  logic cancel = 1'b0;
  logic vend_valid;
  logic [SW-1:0] vend_item;
  logic vend_ready = 1'b0;
  logic chg_valid;
  logic [1:0] chg_coin;
  logic chg_ready = 1'b0;
  logic [CW-1:0] credit;
  logic busy, coin_reject, err_sel;

  int n_chk = 0;
  int n_err = 0;
  logic [SW-1:0] vq[$];
  logic [1:0] cq[$];

  vend_ctrl #(
    .CREDIT_W(CW),
    .N_ITEMS(4),
    .SEL_W(SW),
    .ITEM_PRICES({8'd50, 8'd25, 8'd20, 8'd15}),
    .MAX_CREDIT(100),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coin_valid(coin_valid),
    .coin_type(coin_type),
    .sel_valid(sel_valid),
    .sel(sel),
    .cancel(cancel),
    .vend_valid(vend_valid),
    .vend_item(vend_item),
    .vend_ready(vend_ready),
    .chg_valid(chg_valid),
    .chg_coin(chg_coin),
    .chg_ready(chg_ready),
    .credit(credit),
    .busy(busy),
    .coin_reject(coin_reject),
    .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type = t;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic put_sel(input logic [SW-1:0] s);
    sel_valid = 1'b1;
    sel = s;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic put_cancel;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) tick();
    chk(tag, {31'b0, busy}, 0);
    chk({tag, "_cr"}, credit, 0);
  endtask

  // scoreboard: pop expectations on every handshake
  always @(negedge clk) begin
    if (reset) begin
      if (vend_valid && chg_valid) chk("excl", 1, 0);
      if (vend_valid && vend_ready) begin
        if (vq.size() == 0) chk("vend_unexp", 1, 0);
        else chk("vend_item", vend_item, vq.pop_front());
      end
      if (chg_valid && chg_ready) begin
        if (cq.size() == 0) chk("chg_unexp", 1, 0);
        else chk("chg_coin", chg_coin, cq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vend", vend_valid, 0);
    chk("rst_chg", chg_valid, 0);
    reset = 1'b1;
    tick();

    // 25 + 10, buy item 2 (25), change 10
    vend_ready = 1'b1;
    chg_ready = 1'b1;
    put_coin(2'b10);
    chk("t1_c25", credit, 25);
    put_coin(2'b01);
    chk("t1_c35", credit, 35);
    vq.push_back(3'd2);
    cq.push_back(2'b01);
    put_sel(3'd2);
    chk("t1_vv", vend_valid, 1);
    chk("t1_busy", busy, 1);
    wait_idle("t1_idle");

    // 100 then 5 overflows
    put_coin(2'b11);
    chk("t2_c100", credit, 100);
    put_coin(2'b00);
    chk("t2_rej", coin_reject, 1);
    chk("t2_cr", credit, 100);
    tick();
    chk("t2_rej_end", coin_reject, 0);
    repeat (4) cq.push_back(2'b10);
    put_cancel();
    wait_idle("t2_idle");

    // unaffordable and out of range selects
    put_coin(2'b01);
    put_coin(2'b00);
    chk("t3_c15", credit, 15);
    put_sel(3'd3);
    chk("t3_err1", err_sel, 1);
    chk("t3_cr1", credit, 15);
    chk("t3_vv1", vend_valid, 0);
    put_sel(3'd5);
    chk("t3_err2", err_sel, 1);
    chk("t3_cr2", credit, 15);
    tick();
    chk("t3_err_end", err_sel, 0);
    chk("t3_vv2", vend_valid, 0);
    cq.push_back(2'b01);
    cq.push_back(2'b00);
    put_cancel();
    wait_idle("t3_idle");

    // refund 40 with hopper stalled
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b00);
    chk("t4_c40", credit, 40);
    chg_ready = 1'b0;
    cq.push_back(2'b10);
    cq.push_back(2'b01);
    cq.push_back(2'b00);
    put_cancel();
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_v", chg_valid, 1);
      chk("t4_hold_c", chg_coin, 2'b10);
      chk("t4_hold_cr", credit, 40);
      tick();
    end
    chg_ready = 1'b1;
    tick();
    chk("t4_cr15", credit, 15);
    tick();
    chk("t4_cr5", credit, 5);
    tick();
    chk("t4_cr0", credit, 0);
    wait_idle("t4_idle");

    // reset while change pending
    put_coin(2'b10);
    put_coin(2'b00);
    chk("t5_c30", credit, 30);
    chg_ready = 1'b0;
    put_cancel();
    chk("t5_pend", chg_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("t5_r_cr", credit, 0);
    chk("t5_r_chg", chg_valid, 0);
    chk("t5_r_busy", busy, 0);
    chk("t5_r_coin", chg_coin, 0);
    #1 reset = 1'b1;
    chg_ready = 1'b1;
    tick();
    put_coin(2'b00);
    chk("t5_c5", credit, 5);
    cq.push_back(2'b00);
    put_cancel();
    wait_idle("t5_idle");

    // inactivity with credit 10
    put_coin(2'b01);
    chk("t6_c10", credit, 10);
`ifdef VEND_TIMEOUT_EN
    cq.push_back(2'b01);
    for (int i = 0; i < 40 && credit != 0; i++) tick();
    wait_idle("t6_tmo");
`else
    repeat (20) tick();
    chk("t6_hold", credit, 10);
    chk("t6_nochg", chg_valid, 0);
    cq.push_back(2'b01);
    put_cancel();
    wait_idle("t6_idle");
`endif

    tick();
    chk("vq_empty", vq.size(), 0);
    chk("cq_empty", cq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
